// File: rtl/elevator_pkg.sv
// Shared types and helpers for the single-car elevator scheduler.
//   sim_state_t : car phase, encoded exactly as the VGA controller expects
//   decision_t  : next phase plus the direction preference that goes with it
//   any_above / any_below : is any call pending strictly above/below a floor
//   decide      : SCAN choice made from the pending map, a floor and a direction
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 8;
  localparam int DEFAULT_FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    MOVING_UP   = 2'b01,
    MOVING_DOWN = 2'b10,
    DOORS_OPEN  = 2'b11
  } sim_state_t;

  typedef struct packed {
    sim_state_t state;
    logic       dir_up;
  } decision_t;

  function automatic logic any_above(input logic [DEFAULT_NUM_FLOORS-1:0] vec,
                                     input logic [DEFAULT_FLOOR_W-1:0]    f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEFAULT_NUM_FLOORS; i++) begin
      if (i > int'(f) && vec[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic any_below(input logic [DEFAULT_NUM_FLOORS-1:0] vec,
                                     input logic [DEFAULT_FLOOR_W-1:0]    f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEFAULT_NUM_FLOORS; i++) begin
      if (i < int'(f) && vec[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Serve the current floor first, keep going the same way while calls remain
  // there, otherwise turn around. Direction only changes on a reversal.
  function automatic decision_t decide(input logic [DEFAULT_NUM_FLOORS-1:0] vec,
                                       input logic [DEFAULT_FLOOR_W-1:0]    f,
                                       input logic                          dir_up);
    decision_t d;
    d.state  = IDLE;
    d.dir_up = dir_up;
    if (vec[f]) begin
      d.state = DOORS_OPEN;
    end else if (dir_up && any_above(vec, f)) begin
      d.state = MOVING_UP;
    end else if (!dir_up && any_below(vec, f)) begin
      d.state = MOVING_DOWN;
    end else if (any_above(vec, f)) begin
      d.state  = MOVING_UP;
      d.dir_up = 1'b1;
    end else if (any_below(vec, f)) begin
      d.state  = MOVING_DOWN;
      d.dir_up = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by the travel and door phases.
//   clk, nrst : clock, asynchronous active-low reset (count -> 0)
//   load      : load load_val this edge (takes priority over counting)
//   load_val  : value to load
//   done      : count is zero; the counter holds at zero until reloaded
module elev_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler with SCAN ordering.
//   clk, nrst     : clock, asynchronous active-low reset
//   call_req      : per-floor call requests, sampled every edge
//   door_hold     : keeps the doors open while high (reloads the door timer)
//   sim_state     : 00 IDLE, 01 MOVING_UP, 10 MOVING_DOWN, 11 DOORS_OPEN
//                   (this is the FSM state register itself)
//   destination   : registered map of pending calls
//   current_floor : floor the car is at or last passed
//   dir_up        : direction preference, 1 = up
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W       = DEFAULT_FLOOR_W,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  door_hold,
  output logic [1:0]            sim_state,
  output logic [NUM_FLOORS-1:0] destination,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up
);

  localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  sim_state_t            state, nxt_state;
  logic [NUM_FLOORS-1:0] pending, clear_mask;
  logic [FLOOR_W-1:0]    floor_q, nxt_floor, step_floor;
  logic                  dir_q, nxt_dir;
  logic                  t_load, t_done, take;
  logic [TIMER_W-1:0]    t_val;
  decision_t             dec_here, dec_step, dec;

  elev_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // Floor the car reaches when the current travel slot ends; only used in
  // the move states, where the decision function keeps it in range.
  assign step_floor = (state == MOVING_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
  assign dec_here   = decide(pending, floor_q, dir_q);
  assign dec_step   = decide(pending, step_floor, dir_q);

  always_comb begin
    nxt_state  = state;
    nxt_floor  = floor_q;
    nxt_dir    = dir_q;
    t_load     = 1'b0;
    t_val      = TRAVEL_LOAD;
    clear_mask = '0;
    take       = 1'b0;
    dec        = dec_here;
    case (state)
      IDLE: take = 1'b1;
      MOVING_UP, MOVING_DOWN: begin
        if (t_done) begin
          take      = 1'b1;
          dec       = dec_step;
          nxt_floor = step_floor;
        end
      end
      DOORS_OPEN: begin
        if (door_hold) begin
          t_load = 1'b1;
          t_val  = DOOR_LOAD;
        end else if (t_done) begin
          take = 1'b1;
        end
      end
      default: ;
    endcase
    if (take) begin
      nxt_state = dec.state;
      nxt_dir   = dec.dir_up;
      case (dec.state)
        MOVING_UP, MOVING_DOWN: begin
          t_load = 1'b1;
          t_val  = TRAVEL_LOAD;
        end
        DOORS_OPEN: begin
          // Serving a floor retires its call, including one arriving this edge.
          t_load     = 1'b1;
          t_val      = DOOR_LOAD;
          clear_mask = NUM_FLOORS'(1) << nxt_floor;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      pending <= '0;
      floor_q <= '0;
      dir_q   <= 1'b1;
    end else begin
      state   <= nxt_state;
      pending <= (pending | call_req) & ~clear_mask;
      floor_q <= nxt_floor;
      dir_q   <= nxt_dir;
    end
  end

  a_floor_range: assert property (@(posedge clk) disable iff (!nrst)
    !(t_done && ((state == MOVING_UP && floor_q == FLOOR_W'(NUM_FLOORS - 1)) ||
                 (state == MOVING_DOWN && floor_q == '0))));

  assign sim_state     = state;
  assign destination   = pending;
  assign current_floor = floor_q;
  assign dir_up        = dir_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

  localparam int NF     = 8;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  // clock / reset
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [NF-1:0] call_req  = '0;
  logic          door_hold = 1'b0;
  logic [1:0]    sim_state;
  logic [NF-1:0] destination;
  logic [2:0]    current_floor;
  logic          dir_up;

  int checks   = 0;
  int failures = 0;

  // expected stop floors, in order, for the scenario being run
  logic [2:0] exp_q[$];

  elevator_scheduler #(
    .NUM_FLOORS    (NF),
    .FLOOR_W       (3),
    .TRAVEL_CYCLES (TRAVEL),
    .DOOR_CYCLES   (DOOR)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .call_req      (call_req),
    .door_hold     (door_hold),
    .sim_state     (sim_state),
    .destination   (destination),
    .current_floor (current_floor),
    .dir_up        (dir_up)
  );

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Phase codes are the displayed values; m_elapsed counts cycles spent in the
  // current phase (door phase restarts its count on every held cycle).
  int m_state   = 0;
  int m_floor   = 0;
  int m_elapsed = 0;
  bit m_dir     = 1'b1;
  bit m_pend[NF];

  function automatic void model_decide(input bit pend[NF], input int f, input bit dir_in,
                                       output int st, output bit dir_out);
    int above = 0;
    int below = 0;
    for (int i = 0; i < NF; i++) begin
      if (pend[i] && i > f) above++;
      if (pend[i] && i < f) below++;
    end
    dir_out = dir_in;
    if (pend[f])                    st = 3;
    else if (dir_in && above > 0)   st = 1;
    else if (!dir_in && below > 0)  st = 2;
    else if (above > 0) begin st = 1; dir_out = 1'b1; end
    else if (below > 0) begin st = 2; dir_out = 1'b0; end
    else                            st = 0;
  endfunction

  always @(posedge clk or negedge nrst) begin
    int st;
    int f;
    int el;
    bit d;
    bit take;
    int dst;
    bit dd;
    bit p[NF];
    if (!nrst) begin
      m_state   <= 0;
      m_floor   <= 0;
      m_elapsed <= 0;
      m_dir     <= 1'b1;
      for (int i = 0; i < NF; i++) m_pend[i] <= 1'b0;
    end else begin
      st   = m_state;
      f    = m_floor;
      el   = m_elapsed;
      d    = m_dir;
      take = 1'b0;
      for (int i = 0; i < NF; i++) p[i] = m_pend[i] | call_req[i];
      case (m_state)
        0: take = 1'b1;
        1, 2: begin
          el = el + 1;
          if (el == TRAVEL) begin
            f = (m_state == 1) ? f + 1 : f - 1;
            if (f < 0) f = 0;
            if (f > NF - 1) f = NF - 1;
            take = 1'b1;
          end
        end
        default: begin
          if (door_hold) el = 0;
          else el = el + 1;
          if (el == DOOR) take = 1'b1;
        end
      endcase
      if (take) begin
        model_decide(m_pend, f, m_dir, dst, dd);
        st = dst;
        d  = dd;
        el = 0;
        if (dst == 3) p[f] = 1'b0;
      end
      m_state   <= st;
      m_floor   <= f;
      m_elapsed <= el;
      m_dir     <= d;
      for (int i = 0; i < NF; i++) m_pend[i] <= p[i];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NF-1:0] exp_dest;
    if (nrst === 1'b1) begin
      for (int i = 0; i < NF; i++) exp_dest[i] = m_pend[i];
      check("cyc_state", int'(sim_state), m_state);
      check("cyc_destination", int'(destination), int'(exp_dest));
      check("cyc_floor", int'(current_floor), m_floor);
      check("cyc_dir_up", int'(dir_up), int'(m_dir));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_call(input logic [NF-1:0] v);
    call_req = v;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst      = 1'b0;
    call_req  = '0;
    door_hold = 1'b0;
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_doors(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sim_state == 2'b11) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("doors_reached", int'(hit), 1);
    if (hit) begin
      if (exp_q.size() == 0) check("stop_expected", 0, 1);
      else check("stop_floor", int'(current_floor), int'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_leave(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sim_state != 2'b11) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("doors_left", int'(hit), 1);
  endtask

  task automatic wait_move_at(input int f, input logic [1:0] st, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(current_floor) == f && sim_state == st) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("move_reached", int'(hit), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    check("rst_state", int'(sim_state), 0);
    check("rst_destination", int'(destination), 0);
    check("rst_floor", int'(current_floor), 0);
    check("rst_dir_up", int'(dir_up), 1);

    // single call to floor 3 from floor 0
    pulse_call(8'h08);
    check("s1_dest_latched", int'(destination), 8'h08);
    check("s1_still_idle", int'(sim_state), 0);
    cycles(1);
    check("s1_moving_up", int'(sim_state), 1);
    check("s1_floor0", int'(current_floor), 0);
    cycles(11);
    check("s1_floor2", int'(current_floor), 2);
    check("s1_still_up", int'(sim_state), 1);
    cycles(1);
    check("s1_floor3", int'(current_floor), 3);
    check("s1_doors", int'(sim_state), 3);
    check("s1_dest_clear", int'(destination), 0);
    cycles(2);
    check("s1_doors_last", int'(sim_state), 3);
    cycles(1);
    check("s1_idle", int'(sim_state), 0);

    // call for the floor the idle car is on
    do_reset();
    pulse_call(8'h01);
    check("s2_idle", int'(sim_state), 0);
    cycles(1);
    check("s2_doors", int'(sim_state), 3);
    check("s2_dest", int'(destination), 0);
    cycles(3);
    check("s2_idle_after", int'(sim_state), 0);
    check("s2_no_move", int'(current_floor), 0);

    // calls above and below while moving up
    do_reset();
    pulse_call(8'h40);
    wait_move_at(2, 2'b01, 40);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd0);
    pulse_call(8'h11);
    wait_doors(40);
    wait_leave(20);
    wait_doors(40);
    wait_leave(20);
    check("s3_reverse_dir", int'(dir_up), 0);
    check("s3_reverse_state", int'(sim_state), 2);
    wait_doors(60);
    wait_leave(20);
    check("s3_end_idle", int'(sim_state), 0);
    check("s3_end_dest", int'(destination), 0);

    // door hold at floor 3
    do_reset();
    exp_q.push_back(3'd3);
    pulse_call(8'h08);
    wait_doors(40);
    cnt = 1;
    door_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sim_state == 2'b11) cnt++;
    end
    door_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sim_state == 2'b11) cnt++;
      else break;
    end
    check("s4_hold_dwell", cnt, 8);

    // idle at floor 4, calls at both ends, preference up
    do_reset();
    exp_q.push_back(3'd4);
    pulse_call(8'h10);
    wait_doors(40);
    wait_leave(20);
    check("s5_idle_at4", int'(current_floor), 4);
    check("s5_dir_pref", int'(dir_up), 1);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    pulse_call(8'h81);
    wait_doors(40);
    wait_leave(20);
    wait_doors(80);
    wait_leave(20);
    check("s5_end_idle", int'(sim_state), 0);

    // asynchronous reset while moving down through floor 5
    do_reset();
    exp_q.push_back(3'd7);
    pulse_call(8'h80);
    wait_doors(60);
    pulse_call(8'h03);
    wait_move_at(5, 2'b10, 60);
    check("s6_dest_before", int'(destination), 8'h03);
    #2;
    nrst = 1'b0;
    #1;
    check("s6_rst_state", int'(sim_state), 0);
    check("s6_rst_dest", int'(destination), 0);
    check("s6_rst_floor", int'(current_floor), 0);
    check("s6_rst_dir", int'(dir_up), 1);
    @(negedge clk);
    nrst = 1'b1;
    cycles(8);
    check("s6_stays_idle", int'(sim_state), 0);
    check("s6_stays_empty", int'(destination), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
